// File: rtl/led_ctrl_pkg.sv
// Shared constants and encodings for the LED rate controller.
package led_ctrl_pkg;
  localparam int RATE_W              = 3;
  localparam int NUM_RATES_DEF       = 8;
  localparam int CNT_W               = 24;
  localparam int DEBOUNCE_CYCLES_DEF = 100_000;     // 10 ms @ 10 MHz
  localparam int BASE_PERIOD_DEF     = 10_000_000;  // 1 Hz @ 10 MHz

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;
endpackage

// File: rtl/led_rate_ctrl_btn_debounce.sv
// Per-button 2-FF synchroniser, stable-level debouncer and registered rising-edge pulse.
module btn_debounce
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2, level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level_o <= 1'b0;
      level_d <= 1'b0;
      press_o <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn_i;
      sync2   <= sync1;
      level_d <= level_o;
      press_o <= level_o & ~level_d;
      // any agreeing sample restarts the stability window
      if (sync2 == level_o) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level_o <= sync2;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/led_rate_ctrl.sv
// Button-driven rate/direction controller emitting a tick strobe for the LED rotator.
// Optional pause button and freeze logic enabled by LED_RATE_PAUSE_EN.
module led_rate_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int BASE_PERIOD     = BASE_PERIOD_DEF,
  parameter int NUM_RATES       = NUM_RATES_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              btn_faster_i,
  input  logic              btn_slower_i,
  input  logic              btn_dir_i,
`ifdef LED_RATE_PAUSE_EN
  input  logic              btn_pause_i,
`endif
  output logic              tick_o,
  output logic              dir_o,
  output logic [RATE_W-1:0] rate_idx_o
);
  localparam int BTN_FASTER = 0;
  localparam int BTN_SLOWER = 1;
  localparam int BTN_DIR    = 2;
`ifdef LED_RATE_PAUSE_EN
  localparam int NUM_BTNS   = 4;
  localparam int BTN_PAUSE  = 3;
`else
  localparam int NUM_BTNS   = 3;
`endif
  localparam logic [RATE_W-1:0] RATE_MAX = RATE_W'(NUM_RATES - 1);

  logic [NUM_BTNS-1:0] raw, press, levels_unused;
  logic [RATE_W-1:0]   rate_nxt;
  logic [CNT_W-1:0]    cnt, period;
  logic                rate_chg, wrap, paused;

`ifdef LED_RATE_PAUSE_EN
  assign raw = {btn_pause_i, btn_dir_i, btn_slower_i, btn_faster_i};
`else
  assign raw = {btn_dir_i, btn_slower_i, btn_faster_i};
`endif

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_i   (raw[g]),
      .level_o (levels_unused[g]),
      .press_o (press[g])
    );
  end

  // opposing presses in one cycle cancel; saturated presses are no-ops
  always_comb begin
    rate_nxt = rate_idx_o;
    if (press[BTN_FASTER] && !press[BTN_SLOWER] && rate_idx_o != RATE_MAX)
      rate_nxt = rate_idx_o + RATE_W'(1);
    else if (press[BTN_SLOWER] && !press[BTN_FASTER] && rate_idx_o != '0)
      rate_nxt = rate_idx_o - RATE_W'(1);
  end

  assign rate_chg = (rate_nxt != rate_idx_o);
  assign period   = CNT_W'(BASE_PERIOD) >> rate_idx_o;
  assign wrap     = (cnt == period - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rate_idx_o <= '0;
      dir_o      <= DIR_LEFT;
      cnt        <= '0;
      tick_o     <= 1'b0;
    end else begin
      rate_idx_o <= rate_nxt;
      if (press[BTN_DIR]) dir_o <= ~dir_o;
      // a rate change abandons the current period, even while paused
      tick_o <= wrap && !rate_chg && !paused;
      if (rate_chg)     cnt <= '0;
      else if (!paused) cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end

`ifdef LED_RATE_PAUSE_EN
  always_ff @(posedge clk) begin
    if (!reset_n)              paused <= 1'b0;
    else if (press[BTN_PAUSE]) paused <= ~paused;
  end
`else
  assign paused = 1'b0;
`endif
endmodule

// File: tb/tb_led_rate_ctrl.sv
// Randomised + directed bench for led_rate_ctrl against a behavioural reference model.
module tb_led_rate_ctrl;
  localparam int D  = 4;
  localparam int B  = 256;
  localparam int NR = 8;
  localparam int NB = 4;  // faster, slower, dir, pause

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NB-1:0] btn = '0;
  logic          tick, dir;
  logic [2:0]    rate;

  always #5 clk = ~clk;

  led_rate_ctrl #(.DEBOUNCE_CYCLES(D), .BASE_PERIOD(B), .NUM_RATES(NR)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_faster_i (btn[0]),
    .btn_slower_i (btn[1]),
    .btn_dir_i    (btn[2]),
`ifdef LED_RATE_PAUSE_EN
    .btn_pause_i  (btn[3]),
`endif
    .tick_o       (tick),
    .dir_o        (dir),
    .rate_idx_o   (rate)
  );

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      if (n_fail <= 25) $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a level is accepted once the last D synchronised samples all
  // disagree with it; the press acts two edges after acceptance.
  bit [1:0] m_hist [NB];
  bit       m_win  [NB][$];
  bit       m_lvl [NB], m_rise [NB], m_prs [NB];
  bit       act [NB];
  int       m_rate, m_cnt, per, nr;
  bit       m_tick, m_dir, m_paused, s, all_diff, chg;

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int b = 0; b < NB; b++) begin
        m_hist[b] = '0; m_win[b].delete();
        m_lvl[b] = 0; m_rise[b] = 0; m_prs[b] = 0;
      end
      m_rate = 0; m_cnt = 0; m_tick = 0; m_dir = 0; m_paused = 0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        act[b]    = m_prs[b];
        m_prs[b]  = m_rise[b];
        m_rise[b] = 0;
        s         = m_hist[b][1];
        m_hist[b] = {m_hist[b][0], btn[b]};
        m_win[b].push_back(s);
        if (m_win[b].size() > D) void'(m_win[b].pop_front());
        if (m_win[b].size() == D) begin
          all_diff = 1;
          foreach (m_win[b][j]) if (m_win[b][j] == m_lvl[b]) all_diff = 0;
          if (all_diff) begin
            m_lvl[b]  = !m_lvl[b];
            m_rise[b] = m_lvl[b];
            m_win[b].delete();
          end
        end
      end
      per = B >> m_rate;
      nr  = m_rate;
      if (act[0] && !act[1] && m_rate < NR - 1) nr = m_rate + 1;
      else if (act[1] && !act[0] && m_rate > 0) nr = m_rate - 1;
      chg    = (nr != m_rate);
      m_tick = !m_paused && !chg && (m_cnt == per - 1);
      if (chg) m_cnt = 0;
      else if (!m_paused) m_cnt = (m_cnt == per - 1) ? 0 : m_cnt + 1;
      m_rate = nr;
      if (act[2]) m_dir = !m_dir;
`ifdef LED_RATE_PAUSE_EN
      if (act[3]) m_paused = !m_paused;
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tick", int'(tick), int'(m_tick));
      chk("dir", int'(dir), int'(m_dir));
      chk("rate", int'(rate), m_rate);
    end
  end

  task automatic press(input logic [NB-1:0] m, input int hold, input int gap);
    btn = m;
    repeat (hold) @(negedge clk);
    btn = '0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int k, t_chg, t_tick, nticks;
    bit found;

    repeat (3) @(negedge clk);
    chk("rst_tick", int'(tick), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_rate", int'(rate), 0);
    chk_en  = 1;
    reset_n = 1;

    // steady state: first tick BASE_PERIOD cycles after release
    k = 0; found = 0;
    while (!found && k < 1000) begin
      @(negedge clk); k++;
      if (tick) found = 1;
    end
    chk("first_tick", k, B);
    repeat (300) @(negedge clk);

    // faster held 12 cycles: change 7 edges after first high sample, then period 128
    btn[0] = 1; t_chg = 0; t_tick = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (rate == 3'd1 && t_chg == 0) t_chg = i;
      if (tick && t_chg != 0 && t_tick == 0) t_tick = i;
      if (i == 12) btn[0] = 0;
    end
    chk("press_latency", t_chg, 8);
    chk("tick_after_chg", t_tick - t_chg, 128);

    // bounce then stable high: one increment; 3-cycle glitch: nothing
    press(4'b0001, 1, 1); press(4'b0001, 1, 1); press(4'b0001, 10, 20);
    chk("bounce", int'(rate), 2);
    press(4'b0001, 3, 20);
    chk("glitch", int'(rate), 2);

    // saturation at both ends and cancelling presses
    repeat (9) press(4'b0001, 8, 8);
    chk("sat_hi", int'(rate), 7);
    repeat (20) @(negedge clk);
    press(4'b0011, 8, 8);
    chk("both", int'(rate), 7);
    repeat (9) press(4'b0010, 8, 8);
    chk("sat_lo", int'(rate), 0);
    press(4'b0010, 8, 8);
    chk("slow_at_0", int'(rate), 0);

    // dir toggle mid-period, then a 1-cycle reset at idx 3
    repeat (3) press(4'b0001, 8, 8);
    repeat (10) @(negedge clk);
    press(4'b0100, 8, 40);
    chk("dir_toggle", int'(dir), 1);
    repeat (13) @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    chk("mid_rst_tick", int'(tick), 0);
    chk("mid_rst_dir", int'(dir), 0);
    chk("mid_rst_rate", int'(rate), 0);
    reset_n = 1;
    repeat (150) @(negedge clk);

`ifdef LED_RATE_PAUSE_EN
    press(4'b1000, 8, 8);
    nticks = 0;
    repeat (1000) begin @(negedge clk); if (tick) nticks++; end
    chk("paused_ticks", nticks, 0);
    press(4'b0101, 8, 20);
    press(4'b1000, 8, 400);
`endif

    for (int it = 0; it < 250; it++) begin
      logic [NB-1:0] m;
      m = NB'($urandom_range(0, 7));
`ifdef LED_RATE_PAUSE_EN
      if ($urandom_range(0, 9) == 0) m[3] = 1'b1;
`endif
      press(m, $urandom_range(1, 12), $urandom_range(0, 30));
    end
    repeat (300) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
